convertidor_bcd_binario: RTL and testbench



---
 rtl/convertidor_bcd_binario.sv | 131 +++++++++++++
 tb/tb_convertidor_bcd_binario.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/convertidor_bcd_binario.sv
// convertidor_bcd_binario
// Sequential BCD-to-binary converter (reverse double-dabble). Three BCD digits
// are captured on a start strobe, then 8 shift-right/correct iterations move the
// value into an 8-bit binary register. The result is registered and flagged with
// a one-cycle done pulse.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   start    in   1  conversion request, sampled when not shifting
//   Pnum     in   4  hundreds BCD digit
//   Snum     in   4  tens BCD digit
//   Tnum     in   4  units BCD digit
//   numero   out  8  binary result (registered, holds until next done)
//   busy     out  1  conversion in progress
//   done     out  1  one-cycle result-valid pulse
//   error    out  1  invalid-input flag, valid with done
//
// Optional feature: define CONVERTIDOR_VALIDACION_EN to enable input validation
// (any digit > 9 or value > 255 sets error and forces numero to 0). When the
// macro is undefined error is tied low and values 256-999 wrap modulo 256.
module convertidor_bcd_binario (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] Pnum,
  input  logic [3:0] Snum,
  input  logic [3:0] Tnum,
  output logic [7:0] numero,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]  r_state;
  logic [11:0] r_bcd;
  logic [7:0]  r_bin;
  logic [3:0]  r_cnt;
  logic [7:0]  r_numero;

  logic [19:0] w_shift;
  logic [11:0] w_bcd_sh;
  logic [7:0]  w_bin_sh;
  logic [7:0]  w_result;
  logic        w_capture;
  logic        w_last;

  // A digit that received a 1 from the digit above now reads 8 + d/2 but must
  // represent 5 + d/2, hence the subtract-3 correction.
  function automatic logic [3:0] fix_digit(input logic [3:0] d);
    return (d >= 4'd8) ? d - 4'd3 : d;
  endfunction

  assign w_shift  = {r_bcd, r_bin} >> 1;
  assign w_bin_sh = w_shift[7:0];
  assign w_bcd_sh = {fix_digit(w_shift[19:16]), fix_digit(w_shift[15:12]),
                     fix_digit(w_shift[11:8])};

  // DONE also accepts a new start: its exit edge is the earliest legal
  // back-to-back start edge, nine clocks after the previous one.
  assign w_capture = (r_state != StShift) && start;
  assign w_last    = (r_state == StShift) && (r_cnt == 4'd7);

`ifdef CONVERTIDOR_VALIDACION_EN
  logic w_invalid;
  logic r_err_pend;
  logic r_error;

  assign w_invalid = (Snum > 4'd9) || (Tnum > 4'd9) || (Pnum > 4'd2) ||
                     ((Pnum == 4'd2) && ((Snum > 4'd5) ||
                                         ((Snum == 4'd5) && (Tnum > 4'd5))));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_pend <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_capture) r_err_pend <= w_invalid;
      if (w_last)    r_error    <= r_err_pend;
    end
  end

  assign w_result = r_err_pend ? 8'h00 : w_bin_sh;
  assign error    = r_error;
`else
  assign w_result = w_bin_sh;
  assign error    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_bcd    <= 12'h000;
      r_bin    <= 8'h00;
      r_cnt    <= 4'd0;
      r_numero <= 8'h00;
    end else begin
      case (r_state)
        StShift: begin
          r_bcd <= w_bcd_sh;
          r_bin <= w_bin_sh;
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_numero <= w_result;
            r_state  <= StDone;
          end
        end
        default: begin
          // StIdle, StDone and any illegal encoding
          if (w_capture) begin
            r_bcd   <= {Pnum, Snum, Tnum};
            r_bin   <= 8'h00;
            r_cnt   <= 4'd0;
            r_state <= StShift;
          end else begin
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  assign numero = r_numero;
  assign busy   = (r_state == StShift);
  assign done   = (r_state == StDone);

endmodule

// File: tb/tb_convertidor_bcd_binario.sv
module tb_convertidor_bcd_binario;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pnum = 4'd0;
  logic [3:0] snum = 4'd0;
  logic [3:0] tnum = 4'd0;
  logic [7:0] numero;
  logic       busy;
  logic       done;
  logic       error;

  convertidor_bcd_binario dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .Pnum    (pnum),
    .Snum    (snum),
    .Tnum    (tnum),
    .numero  (numero),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  n;
    logic        e;
    int unsigned c;
  } exp_t;

  typedef struct {
    logic [3:0] p;
    logic [3:0] s;
    logic [3:0] t;
    logic [7:0] n;
    logic       e;
  } vec_t;

  exp_t        sb[$];
  exp_t        m_x;
  vec_t        vecs[8];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned last_done = 0;
  int unsigned prev_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (reset_n && done) begin
      check("done_busy_exclusive", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        m_x = sb.pop_front();
        check("numero", {24'd0, numero}, {24'd0, m_x.n});
        check("error", {31'd0, error}, {31'd0, m_x.e});
        check("latency", cyc - m_x.c, 32'd8);
      end
      prev_done = last_done;
      last_done = cyc;
    end
  end

  // Called at a negedge; start stays high for `hold` rising edges.
  task automatic issue(input logic [3:0] p, input logic [3:0] s, input logic [3:0] t,
                       input logic [7:0] n, input logic e, input int hold, input bit track);
    pnum  = p;
    snum  = s;
    tnum  = t;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (track) sb.push_back('{n: n, e: e, c: cyc});
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 1; i < hold; i++) @(negedge clk);
    start = 1'b0;
    pnum  = 4'($urandom);
    snum  = 4'($urandom);
    tnum  = 4'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd2, 4'd5, 4'd5, 8'hFF, 1'b0};
    vecs[1] = '{4'd0, 4'd0, 4'd1, 8'h01, 1'b0};
    vecs[2] = '{4'd1, 4'd9, 4'd9, 8'hC7, 1'b0};
    vecs[4] = '{4'd0, 4'd9, 4'd9, 8'h63, 1'b0};
    vecs[7] = '{4'd1, 4'd2, 4'd8, 8'h80, 1'b0};
`ifdef CONVERTIDOR_VALIDACION_EN
    vecs[3] = '{4'd9, 4'd9, 4'd9, 8'h00, 1'b1};
    vecs[5] = '{4'd2, 4'd5, 4'd6, 8'h00, 1'b1};
    vecs[6] = '{4'd3, 4'd0, 4'd0, 8'h00, 1'b1};
`else
    vecs[3] = '{4'd9, 4'd9, 4'd9, 8'hE7, 1'b0};
    vecs[5] = '{4'd2, 4'd5, 4'd6, 8'h00, 1'b0};
    vecs[6] = '{4'd3, 4'd0, 4'd0, 8'h2C, 1'b0};
`endif

    // Reset state
    #1;
    check("rst_numero", {24'd0, numero}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single conversions from the table
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].p, vecs[i].s, vecs[i].t, vecs[i].n, vecs[i].e, 1, 1'b1);
      drain();
    end

    // Back-to-back at the earliest legal edge k+9
    issue(4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1, 1'b1);
    repeat (8) @(negedge clk);
    issue(4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 1, 1'b1);
    drain();
    check("b2b_done_spacing", last_done - prev_done, 32'd9);

    // Start held for 4 edges: one conversion, one done
    issue(4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, 4, 1'b1);
    drain();
    repeat (12) @(negedge clk);

    // Asynchronous reset during the 4th shift cycle
    issue(4'd1, 4'd0, 4'd0, 8'h64, 1'b0, 1, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_numero", {24'd0, numero}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_error", {31'd0, error}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(4'd1, 4'd0, 4'd0, 8'h64, 1'b0, 1, 1'b1);
    drain();

`ifdef CONVERTIDOR_VALIDACION_EN
    // Invalid digit then a valid conversion clears error
    issue(4'd0, 4'hA, 4'd0, 8'h00, 1'b1, 1, 1'b1);
    drain();
    check("err_holds", {31'd0, error}, 32'd1);
    issue(4'd0, 4'd1, 4'd5, 8'h0F, 1'b0, 1, 1'b1);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
